// File: rtl/reduce_xor_stream.sv
// reduce_xor_stream
//   Pipelined, handshaked XOR reducer. Each accepted beat carries NUM_ELEMENTS
//   words of ELEMENT_WIDTH bits. They are folded by a registered FAN_IN-ary XOR
//   tree. The per-beat reductions are accumulated over a frame that closes on
//   in_last, and the frame result is presented on out_xor with a valid/ready
//   handshake. A single global enable stalls the whole pipeline under output
//   backpressure, so no beat is lost or duplicated.
//
// Ports
//   in_clock     rising-edge clock
//   in_reset     synchronous, active-high reset
//   in_elements  packed words, element j at bits [j*ELEMENT_WIDTH +: ELEMENT_WIDTH]
//   in_valid     beat present
//   in_last      beat closes the current frame
//   in_ready     beat accepted when in_valid && in_ready at a rising edge
//   out_xor      frame result (holds its value while out_valid is low)
//   out_valid    out_xor valid
//   out_ready    consumer accepts when out_valid && out_ready
module reduce_xor_stream #(
  parameter int NUM_ELEMENTS  = 5,
  parameter int ELEMENT_WIDTH = 4,
  parameter int FAN_IN        = 2
) (
  input  logic                                  in_clock,
  input  logic                                  in_reset,
  input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] in_elements,
  input  logic                                  in_valid,
  input  logic                                  in_last,
  output logic                                  in_ready,
  output logic [ELEMENT_WIDTH-1:0]              out_xor,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int W = ELEMENT_WIDTH;

  // Number of words present at tree level k (level 0 is the input beat).
  function automatic int level_count(input int k);
    int n;
    n = NUM_ELEMENTS;
    for (int i = 0; i < k; i++) n = (n + FAN_IN - 1) / FAN_IN;
    return n;
  endfunction

  // max(1, ceil(log_FAN_IN(NUM_ELEMENTS))), found by repeated division so a
  // non-power-of-two fan-in is handled exactly.
  function automatic int num_stages();
    int n;
    int s;
    n = NUM_ELEMENTS;
    s = 0;
    for (int i = 0; i < 32; i++) begin
      if (n > 1) begin
        n = (n + FAN_IN - 1) / FAN_IN;
        s++;
      end
    end
    return (s < 1) ? 1 : s;
  endfunction

  // Bit offset of level k inside the flattened level bus.
  function automatic int level_offset(input int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o += level_count(i) * W;
    return o;
  endfunction

  localparam int S     = num_stages();
  localparam int LVL_W = level_offset(S);

  // Levels 0..S-1 side by side: level 0 is the raw input beat, levels
  // 1..S-1 are pipeline registers. Level S (the root word r) feeds the
  // accumulator directly and is never registered on its own.
  logic [LVL_W-1:0] lvl_words;
  logic [S-1:0]     lvl_valid;
  logic [S-1:0]     lvl_last;
  logic [W-1:0]     r;
  logic             en;

  // Every stage moves together; bubbles are carried, not squeezed out.
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !in_reset;

  assign lvl_words[NUM_ELEMENTS*W-1:0] = in_elements;
  assign lvl_valid[0]                  = in_valid && in_ready;
  assign lvl_last[0]                   = in_last;

  for (genvar k = 1; k <= S; k++) begin : g_stage
    localparam int P_CNT = level_count(k - 1);
    localparam int CNT   = level_count(k);
    localparam int P_OFF = level_offset(k - 1);

    logic [CNT*W-1:0] node_d;

    for (genvar j = 0; j < CNT; j++) begin : g_node
      // Words LO..HI-1 of the previous level; a lone leftover word is a
      // one-term XOR and passes through unchanged.
      localparam int LO = j * FAN_IN;
      localparam int HI = ((j + 1) * FAN_IN < P_CNT) ? (j + 1) * FAN_IN : P_CNT;

      logic [W-1:0] node_x;

      // NOTE: combinational blocks use blocking '=' and assign a default
      // first, so the result is pure logic with no inferred latch.
      always_comb begin
        node_x = '0;
        for (int i = LO; i < HI; i++) node_x = node_x ^ lvl_words[P_OFF + i*W +: W];
      end

      assign node_d[j*W +: W] = node_x;
    end

    if (k < S) begin : g_reg
      localparam int OFF = level_offset(k);

      logic [CNT*W-1:0] words_q;
      logic             valid_q;
      logic             last_q;

      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples pre-edge values regardless of block evaluation order.
      always_ff @(posedge in_clock) begin
        if (in_reset) valid_q <= 1'b0;
        else if (en)  valid_q <= lvl_valid[k-1];
      end

      // NOTE: data words and the last flag are qualified by valid_q, so they
      // carry no reset; only the control bit needs a known value.
      always_ff @(posedge in_clock) begin
        if (en) begin
          words_q <= node_d;
          last_q  <= lvl_last[k-1];
        end
      end

      assign lvl_words[OFF +: CNT*W] = words_q;
      assign lvl_valid[k]            = valid_q;
      assign lvl_last[k]             = last_q;
    end else begin : g_root
      assign r = node_d;
    end
  end

  // Accumulate/output stage, fed by the last tree level (or by the input
  // handshake directly when the tree is a single level).
  logic         beat_valid;
  logic         beat_last;
  logic [W-1:0] acc_q;

  assign beat_valid = lvl_valid[S-1];
  assign beat_last  = lvl_last[S-1];

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      acc_q     <= '0;
      out_xor   <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      // With en high, any held result is being consumed this cycle, so
      // out_valid is high afterwards only if a new frame closes right now.
      out_valid <= beat_valid && beat_last;
      if (beat_valid) begin
        if (beat_last) begin
          out_xor <= acc_q ^ r;
          acc_q   <= '0;
        end else begin
          acc_q   <= acc_q ^ r;
        end
      end
    end
  end

endmodule

// File: tb/tb_reduce_xor_stream.sv
// Testbench for reduce_xor_stream: one instance with N=5, W=4, F=2 (three
// stages) and one with N=1, W=8, F=2 (single stage). Expected frame results
// are hand-computed and queued at acceptance; a monitor per instance pops and
// compares whenever an output transfer happens.
module tb_reduce_xor_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A: N=5, W=4, F=2
  logic        a_reset, a_valid, a_last, a_in_ready, a_out_valid, a_out_ready;
  logic [19:0] a_elements;
  logic [3:0]  a_out_xor;

  // Instance B: N=1, W=8, F=2
  logic        b_reset, b_valid, b_last, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_elements;
  logic [7:0]  b_out_xor;

  logic [3:0] a_exp_q[$];
  logic [7:0] b_exp_q[$];
  int         a_out_cyc[$];
  int         a_out_cnt = 0;
  int         b_out_cnt = 0;

  reduce_xor_stream #(.NUM_ELEMENTS(5), .ELEMENT_WIDTH(4), .FAN_IN(2)) dut_a (
    .in_clock    (clk),
    .in_reset    (a_reset),
    .in_elements (a_elements),
    .in_valid    (a_valid),
    .in_last     (a_last),
    .in_ready    (a_in_ready),
    .out_xor     (a_out_xor),
    .out_valid   (a_out_valid),
    .out_ready   (a_out_ready)
  );

  reduce_xor_stream #(.NUM_ELEMENTS(1), .ELEMENT_WIDTH(8), .FAN_IN(2)) dut_b (
    .in_clock    (clk),
    .in_reset    (b_reset),
    .in_elements (b_elements),
    .in_valid    (b_valid),
    .in_last     (b_last),
    .in_ready    (b_in_ready),
    .out_xor     (b_out_xor),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] pack5(input logic [3:0] e0, input logic [3:0] e1,
                                        input logic [3:0] e2, input logic [3:0] e3,
                                        input logic [3:0] e4);
    return {e4, e3, e2, e1, e0};
  endfunction

  // Monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      a_out_cnt++;
      a_out_cyc.push_back(cyc);
      if (a_exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL a_spurious: got output 0x%0h, required no output", a_out_xor);
      end else begin
        check("a_out_xor", 32'(a_out_xor), 32'(a_exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (b_out_valid && b_out_ready) begin
      b_out_cnt++;
      if (b_exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL b_spurious: got output 0x%0h, required no output", b_out_xor);
      end else begin
        check("b_out_xor", 32'(b_out_xor), 32'(b_exp_q.pop_front()));
      end
    end
  end

  // Present a beat, wait (bounded) for acceptance, queue the frame result.
  // Returns with time just after the accepting edge.
  task automatic send_a(input logic [19:0] d, input logic l, input logic [3:0] exp,
                        output int waits);
    waits      = 0;
    a_elements = d;
    a_last     = l;
    a_valid    = 1'b1;
    @(negedge clk);
    while (!a_in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!a_in_ready) begin
      $display("FAIL a_accept_timeout: in_ready stayed 0, required 1");
      $fatal(1, "instance A never accepted a beat");
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_last  = 1'b0;
    if (l) a_exp_q.push_back(exp);
  endtask

  task automatic send_b(input logic [7:0] d, input logic l, input logic [7:0] exp);
    int waits;
    waits      = 0;
    b_elements = d;
    b_last     = l;
    b_valid    = 1'b1;
    @(negedge clk);
    while (!b_in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!b_in_ready) begin
      $display("FAIL b_accept_timeout: in_ready stayed 0, required 1");
      $fatal(1, "instance B never accepted a beat");
    end
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    b_last  = 1'b0;
    if (l) b_exp_q.push_back(exp);
  endtask

  // Wait (bounded) until every queued result has been seen, then idle a few
  // cycles so any extra output would be caught as spurious.
  task automatic drain();
    int n;
    n = 0;
    while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("a_drain_pending", 32'(a_exp_q.size()), 32'd0);
    check("b_drain_pending", 32'(b_exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Burst vectors: element words e0..e4 and the hand-computed XOR.
  logic [3:0] burst_w[8][5] = '{
    '{4'h0, 4'h0, 4'h0, 4'h0, 4'h9},
    '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0},
    '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1},
    '{4'hA, 4'h5, 4'h0, 4'h0, 4'h0},
    '{4'h3, 4'h6, 4'hC, 4'h9, 4'h0},
    '{4'h7, 4'h7, 4'h7, 4'h0, 4'h1},
    '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA},
    '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB}
  };
  logic [3:0] burst_x[8] = '{4'h9, 4'hF, 4'h1, 4'hF, 4'h0, 4'h6, 4'h2, 4'hB};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int wsum;
    int n0;
    int idx0;

    a_reset = 1'b1; a_valid = 1'b0; a_last = 1'b0; a_elements = '0; a_out_ready = 1'b1;
    b_reset = 1'b1; b_valid = 1'b0; b_last = 1'b0; b_elements = '0; b_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("a_in_ready_in_reset", 32'(a_in_ready), 32'd0);
    check("b_in_ready_in_reset", 32'(b_in_ready), 32'd0);
    @(posedge clk);
    #1;
    a_reset = 1'b0;
    b_reset = 1'b0;
    @(negedge clk);
    check("a_out_valid_after_reset", 32'(a_out_valid), 32'd0);
    check("a_out_xor_after_reset",   32'(a_out_xor),   32'd0);
    check("a_in_ready_after_reset",  32'(a_in_ready),  32'd1);
    check("b_out_valid_after_reset", 32'(b_out_valid), 32'd0);
    check("b_in_ready_after_reset",  32'(b_in_ready),  32'd1);
    @(posedge clk);
    #1;

    // Single beat {1,2,4,8,3} -> 0xC, valid after edge t+2, one-cycle pulse
    send_a(pack5(4'h1, 4'h2, 4'h4, 4'h8, 4'h3), 1'b1, 4'hC, w);
    @(negedge clk); check("lat_after_t",   32'(a_out_valid), 32'd0);
    @(negedge clk); check("lat_after_t+1", 32'(a_out_valid), 32'd0);
    @(negedge clk); check("lat_after_t+2", 32'(a_out_valid), 32'd1);
    @(negedge clk); check("pulse_after_t+3", 32'(a_out_valid), 32'd0);
    drain();

    // 8 back-to-back single-beat frames
    idx0 = a_out_cyc.size();
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      send_a(pack5(burst_w[i][0], burst_w[i][1], burst_w[i][2], burst_w[i][3], burst_w[i][4]),
             1'b1, burst_x[i], w);
      wsum += w;
    end
    drain();
    check("burst_in_ready_waits", 32'(wsum), 32'd0);
    check("burst_out_count", 32'(a_out_cyc.size() - idx0), 32'd8);
    if (a_out_cyc.size() >= idx0 + 8)
      check("burst_out_span", 32'(a_out_cyc[idx0+7] - a_out_cyc[idx0]), 32'd7);

    // Three-beat frame with reductions 1, 2, 4 -> one output of 7
    n0 = a_out_cnt;
    send_a(pack5(4'h1, 4'h0, 4'h0, 4'h0, 4'h0), 1'b0, 4'h0, w);
    send_a(pack5(4'h3, 4'h1, 4'h0, 4'h0, 4'h0), 1'b0, 4'h0, w);
    send_a(pack5(4'h0, 4'h0, 4'h0, 4'h0, 4'h4), 1'b1, 4'h7, w);
    drain();
    check("frame_out_count", 32'(a_out_cnt - n0), 32'd1);

    // Backpressure: fill the pipe, hold out_ready low for 4 cycles
    n0 = a_out_cnt;
    a_out_ready = 1'b0;
    fork
      begin
        int ws;
        send_a(pack5(4'h6, 4'h0, 4'h0, 4'h0, 4'h0), 1'b1, 4'h6, ws);
        send_a(pack5(4'h0, 4'h3, 4'h0, 4'h0, 4'h0), 1'b1, 4'h3, ws);
        send_a(pack5(4'h0, 4'h0, 4'h0, 4'h0, 4'hE), 1'b1, 4'hE, ws);
        send_a(pack5(4'h1, 4'h2, 4'h4, 4'h0, 4'h0), 1'b1, 4'h7, ws);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!a_out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("stall_out_valid", 32'(a_out_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
          check("stall_in_ready", 32'(a_in_ready), 32'd0);
          check("stall_out_xor",  32'(a_out_xor),  32'h6);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
      end
    join
    drain();
    check("stall_out_count", 32'(a_out_cnt - n0), 32'd4);

    // Reset in the middle of a frame discards the partial accumulation
    send_a(pack5(4'h1, 4'h0, 4'h0, 4'h0, 4'h0), 1'b0, 4'h0, w);
    send_a(pack5(4'h2, 4'h0, 4'h0, 4'h0, 4'h0), 1'b0, 4'h0, w);
    a_reset = 1'b1;
    @(negedge clk);
    check("mid_reset_in_ready", 32'(a_in_ready), 32'd0);
    @(posedge clk);
    #1;
    a_reset = 1'b0;
    @(negedge clk);
    check("mid_reset_out_valid", 32'(a_out_valid), 32'd0);
    check("mid_reset_out_xor",   32'(a_out_xor),   32'd0);
    @(posedge clk);
    #1;
    send_a(pack5(4'h5, 4'h0, 4'h0, 4'h0, 4'h0), 1'b1, 4'h5, w);
    drain();

    // Single-stage instance: one-cycle latency, two-beat frame
    send_b(8'hA5, 1'b1, 8'hA5);
    @(negedge clk);
    check("b_latency", 32'(b_out_valid), 32'd1);
    drain();
    n0 = b_out_cnt;
    send_b(8'h0F, 1'b0, 8'h00);
    send_b(8'hF0, 1'b1, 8'hFF);
    drain();
    check("b_frame_out_count", 32'(b_out_cnt - n0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
